// File: rtl/umul_seq.sv
// Iterative 32x32 unsigned shift-add multiplier driving one internal 32-bit adder.
// Define UMUL_EARLY_EXIT_EN to stop once the remaining multiplier bits are zero.
module cla_add32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] sum,
  output logic        carry_out
);
  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;
  logic [3:0]  gg;
  logic [3:0]  pp;

  assign g = a & b;
  assign p = a ^ b;

  // 8-bit groups: group generate/propagate feed a lookahead across groups
  always_comb begin
    gg = '0;
    pp = '1;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 8; i++) begin
        gg[k] = g[8*k+i] | (p[8*k+i] & gg[k]);
        pp[k] = pp[k] & p[8*k+i];
      end
    end
  end

  always_comb begin
    c = '0;
    c[0] = c_in;
    for (int k = 0; k < 4; k++) begin
      c[8*(k+1)] = gg[k] | (pp[k] & c[8*k]);
      for (int i = 1; i < 8; i++)
        c[8*k+i] = g[8*k+i-1] | (p[8*k+i-1] & c[8*k+i-1]);
    end
  end

  assign sum       = p ^ c[31:0];
  assign carry_out = c[32];
endmodule

module umul_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               hi_nz
);
  if (WIDTH != 32) begin : g_width_chk
    $error("umul_seq: WIDTH must be 32");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [31:0] mcand;
  logic [31:0] mplr;
  logic [31:0] acc;
  logic [4:0]  count;
  logic [31:0] addend;
  logic [31:0] sum;
  logic        carry;
  logic [31:0] acc_n;
  logic [31:0] mplr_n;
  logic [63:0] res_n;
  logic        last;

  assign addend = mplr[0] ? mcand : 32'h0;

  cla_add32 u_add (
    .a         (acc),
    .b         (addend),
    .c_in      (1'b0),
    .sum       (sum),
    .carry_out (carry)
  );

  assign acc_n  = {carry, sum[31:1]};
  assign mplr_n = {sum[0], mplr[31:1]};

`ifdef UMUL_EARLY_EXIT_EN
  logic [31:0] rem_mask;
  // low (31-count) bits of mplr_n are the multiplier bits not yet consumed
  assign rem_mask = (32'h1 << (5'd31 - count)) - 32'h1;
  assign last     = ~|(mplr_n & rem_mask);
  assign res_n    = {acc_n, mplr_n} >> (5'd31 - count);
`else
  assign last  = (count == 5'd31);
  assign res_n = {acc_n, mplr_n};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      hi_nz   <= 1'b0;
      mcand   <= '0;
      mplr    <= '0;
      acc     <= '0;
      count   <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            mcand <= a;
            mplr  <= b;
            acc   <= '0;
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc   <= acc_n;
          mplr  <= mplr_n;
          count <= count + 5'd1;
          if (last) begin
            product <= res_n;
            hi_nz   <= |res_n[63:32];
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_umul_seq.sv
// Randomised self-checking bench for umul_seq against a plain 64-bit multiply.
module tb_umul_seq;
  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic        hi_nz;

  int checks = 0;
  int errors = 0;

  umul_seq dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .hi_nz   (hi_nz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input logic [31:0] m);
    int n;
`ifdef UMUL_EARLY_EXIT_EN
    n = 1;
    for (int i = 0; i < 32; i++)
      if (m[i]) n = i + 1;
`else
    n = 32;
`endif
    return n;
  endfunction

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v,
                       input int poke);
    logic [63:0] exp;
    int lat;
    int edges;
    bit got;
    exp = 64'(ta) * 64'(tb_v);
    lat = exp_lat(tb_v);
    a = ta;
    b = tb_v;
    start = 1'b1;
    @(posedge clk);
    edges = 0;
    got = 1'b0;
    while (edges < 40 && !got) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      start = 1'b0;
      a = $urandom;
      b = $urandom;
      if (done) begin
        got = 1'b1;
      end else begin
        check("busy_run", {63'd0, busy}, 64'd1);
        if (edges == poke) begin
          a = 32'd5;
          b = 32'd7;
          start = 1'b1;
        end
      end
    end
    check("done_seen", {63'd0, got}, 64'd1);
    check("latency", 64'(edges), 64'(lat));
    check("product", product, exp);
    check("hi_nz", {63'd0, hi_nz}, {63'd0, |exp[63:32]});
    check("busy_done", {63'd0, busy}, 64'd0);
  endtask

  task automatic tail(input logic [63:0] exp);
    @(negedge clk);
    check("done_pulse", {63'd0, done}, 64'd0);
    check("held", product, exp);
  endtask

  initial begin
    int dones;
    int rst_at;
    logic [31:0] ra;
    logic [31:0] rb;
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_product", product, 64'd0);
    check("rst_hi_nz", {63'd0, hi_nz}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    do_op(32'd13, 32'd64, -1);
    tail(64'h340);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    tail(64'hFFFF_FFFE_0000_0001);
    do_op(32'h1234_5678, 32'd0, -1);
    tail(64'd0);

    // ignored start mid-run, then back-to-back start in the done cycle
    do_op(32'h1_0000, 32'h1_0000, 10);
    do_op(32'd5, 32'd7, -1);
    tail(64'h23);

    // asynchronous reset mid-run
`ifdef UMUL_EARLY_EXIT_EN
    rst_at = 2;
`else
    rst_at = 15;
`endif
    a = 32'd3;
    b = 32'd4;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < rst_at; i++) @(negedge clk);
    check("pre_rst_busy", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    #1;
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_done", {63'd0, done}, 64'd0);
    check("arst_product", product, 64'd0);
    check("arst_hi_nz", {63'd0, hi_nz}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("no_done_after_rst", 64'(dones), 64'd0);
    do_op(32'd3, 32'd4, -1);
    tail(64'hC);

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      do_op(ra, rb, -1);
      if (i % 2 == 0) tail(64'(ra) * 64'(rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
